// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operand width,
// iteration count, op encodings (MIPS funct-derived 2-bit code) and the
// controller state enum.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  localparam int MD_WIDTH      = 32;
  localparam int MD_ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  // MULT and DIV treat operands as two's complement; the U variants do not.
  function automatic logic md_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_addsub33.sv
// -----------------------------------------------------------------------------
// md_addsub33
// 33-bit combinational adder/subtractor shared by the multiply accumulate and
// the divide trial subtraction.
//   a, b  : 33-bit operands
//   sub   : 1 = compute a - b, 0 = compute a + b
//   sum   : 33-bit result
//   cout  : carry out; for subtraction, 1 means a >= b (no borrow)
// -----------------------------------------------------------------------------
module md_addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [32:0] b_eff;

  // Subtraction as a + ~b + 1: invert b bitwise, inject sub as carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < 33; gi++) begin : g_binv
      assign b_eff[gi] = b[gi] ^ sub;
    end
  endgenerate

  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {33'd0, sub};

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Fixed 34-cycle latency: IDLE -> PREP -> RUN (32 iterations) -> FIX -> IDLE.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, op       : request and opcode (sampled only in IDLE)
//   rs_val, rt_val  : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we,
//   wdata           : MTHI/MTLO writes (honoured only in IDLE)
//   busy            : operation in progress
//   done            : one-cycle completion pulse
//   hi, lo          : HI/LO registers
// Build option: define MULT_DIV_DIV_EN to include the divide datapath; without
// it, divide requests are ignored.
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH  // adder is 33 bits, so WIDTH must stay 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(MD_ITER_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER_COUNT - 1);

  md_state_e        state_reg, state_next;
  md_op_e           op_reg;
  logic [WIDTH-1:0] a_raw_reg, b_raw_reg;  // operands as presented
  logic [WIDTH-1:0] opnd_reg;             // multiplicand / divisor magnitude
  logic [WIDTH:0]   acc_reg;              // product high half / remainder
  logic [WIDTH-1:0] low_reg;              // multiplier+product low / quotient
  logic [CNT_W-1:0] cnt_reg;
  logic             sign_a_reg, sign_b_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             accept;
  logic             op_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub, add_cout;
  logic [WIDTH:0]   mult_acc;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULT_DIV_DIV_EN
  logic [WIDTH:0]   rem_shift;
  assign accept = (state_reg == ST_IDLE) && start;
`else
  assign accept = (state_reg == ST_IDLE) && start && !op[1];
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_PREP;
      ST_PREP: state_next = ST_RUN;
      ST_RUN:  if (cnt_reg == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_reg != ST_IDLE);
    done = done_reg;
    hi   = hi_reg;
    lo   = lo_reg;
  end

  // ---------------- operand conditioning ----------------
  assign op_signed = md_is_signed(op_reg);
  assign neg_a     = op_signed & a_raw_reg[WIDTH-1];
  assign neg_b     = op_signed & b_raw_reg[WIDTH-1];
  assign mag_a     = neg_a ? -a_raw_reg : a_raw_reg;
  assign mag_b     = neg_b ? -b_raw_reg : b_raw_reg;

  // ---------------- shared 33-bit adder ----------------
  always_comb begin
    add_a   = acc_reg;
    add_b   = {1'b0, opnd_reg};
    add_sub = 1'b0;
`ifdef MULT_DIV_DIV_EN
    // Restoring divide: trial-subtract divisor from the left-shifted remainder.
    rem_shift = {acc_reg[WIDTH-1:0], low_reg[WIDTH-1]};
    if (op_reg[1]) begin
      add_a   = rem_shift;
      add_sub = 1'b1;
    end
`endif
  end

  md_addsub33 u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign mult_acc = low_reg[0] ? add_sum : acc_reg;

  // ---------------- result fix-up ----------------
  always_comb begin
    prod     = {acc_reg[WIDTH-1:0], low_reg};
    prod_fix = (sign_a_reg ^ sign_b_reg) ? -prod : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MULT_DIV_DIV_EN
    if (op_reg[1]) begin
      if (b_raw_reg == '0) begin
        // Divide by zero: fixed architectural result, no sign handling.
        fix_hi = a_raw_reg;
        fix_lo = '1;
      end else begin
        // Quotient sign = sign_a ^ sign_b; remainder follows the dividend.
        fix_lo = (sign_a_reg ^ sign_b_reg) ? -low_reg : low_reg;
        fix_hi = sign_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      end
    end
`endif
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= OP_MULT;
      a_raw_reg  <= '0;
      b_raw_reg  <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      low_reg    <= '0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (accept) begin
            op_reg    <= md_op_e'(op);
            a_raw_reg <= rs_val;
            b_raw_reg <= rt_val;
          end
        end
        ST_PREP: begin
          sign_a_reg <= neg_a;
          sign_b_reg <= neg_b;
          acc_reg    <= '0;
          low_reg    <= mag_a;
          opnd_reg   <= mag_b;
          cnt_reg    <= CNT_LAST;
        end
        ST_RUN: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
`ifdef MULT_DIV_DIV_EN
          if (op_reg[1]) begin
            if (add_cout) begin
              acc_reg <= add_sum;
              low_reg <= {low_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_reg <= rem_shift;
              low_reg <= {low_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
`else
          begin
`endif
            // Shift-add: {acc, multiplier} shifts right one after the add.
            acc_reg <= {1'b0, mult_acc[WIDTH:1]};
            low_reg <= {mult_acc[0], low_reg[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Carry out only matters for the divide trial subtraction.
  logic unused_bits;
  assign unused_bits = ^{add_cout, op_reg[1]};

endmodule
